correlator_sequencer: RTL and testbench

//  Sequences one sign_selector add/subtract correlator across a window of REF_LEN chips.

---
 rtl/correlator_sequencer.sv | 172 +++++++++++++++++
 tb/tb_correlator_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/correlator_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : correlator_sequencer
//  Description : Walks one external add/subtract correlator across a window
//                of REF_LEN chips. Each accepted sample is paired with one
//                chip of a stored +/-1 reference pattern. The first chip of a
//                window overwrites the correlator's stale sum. The final sum
//                is captured one cycle after the last chip and compared
//                against THRESH to raise a detect flag.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1        clock
//    rst          in   1        synchronous, active-high reset
//    ref_wr       in   1        load ref_pattern (IDLE only)
//    ref_pattern  in   REF_LEN  chip i = bit i; 1 -> +1, 0 -> -1
//    start        in   1        begin a window (IDLE only)
//    cont         in   1        sampled at window end; 1 = chain next window
//    sample_valid in   1        sample qualifier
//    sample       in   2        signed sample
//    corr_in      out  2        sample forwarded to the correlator
//    corr_ref     out  8        chip: 8'h01 = +1, 8'hFF = -1, 8'h00 = hold
//    corr_clr     out  1        correlator load-instead-of-accumulate
//    corr_acc     in   8        correlator running sum (signed)
//    result       out  8        captured window sum (signed)
//    result_valid out  1        one-cycle pulse when result/detect update
//    detect       out  1        |result| >= THRESH
//    busy         out  1        high in RUN and WAIT
// ============================================================================
module correlator_sequencer #(
    parameter int REF_LEN = 32,
    parameter int THRESH  = 40
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ref_wr,
    input  logic [REF_LEN-1:0] ref_pattern,
    input  logic               start,
    input  logic               cont,
    input  logic               sample_valid,
    input  logic [1:0]         sample,
    output logic [1:0]         corr_in,
    output logic [7:0]         corr_ref,
    output logic               corr_clr,
    input  logic [7:0]         corr_acc,
    output logic [7:0]         result,
    output logic               result_valid,
    output logic               detect,
    output logic               busy
);

    localparam int               IDX_W    = 6;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(REF_LEN - 1);
    localparam logic [8:0]       THRESH_9 = 9'(THRESH);
    localparam logic [7:0]       REF_POS  = 8'h01;
    localparam logic [7:0]       REF_NEG  = 8'hFF;
    localparam logic [7:0]       REF_HOLD = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REF_LEN-1:0] pattern_q, pattern_d;
    logic [7:0]         result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic               detect_q, detect_d;

    logic [REF_LEN-1:0] w_pat_shift;
    logic               w_chip;
    logic [8:0]         w_acc_ext;
    logic [8:0]         w_acc_abs;
    logic               w_over;

    // Chip select by shifting rather than indexing, so the 6-bit index never
    // has to match the pattern's address width.
    // The sum is widened to 9 bits before negation so that -128 has a
    // representable magnitude.
    always_comb begin
        w_pat_shift = pattern_q >> idx_q;
        w_chip      = w_pat_shift[0];
        w_acc_ext   = {corr_acc[7], corr_acc};
        w_acc_abs   = w_acc_ext[8] ? (9'd0 - w_acc_ext) : w_acc_ext;
        w_over      = (w_acc_abs >= THRESH_9);
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        pattern_d      = pattern_q;
        result_d       = result_q;
        detect_d       = detect_q;
        result_valid_d = 1'b0;
        corr_in        = 2'b00;
        corr_ref       = REF_HOLD;
        corr_clr       = 1'b0;
        busy           = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The pattern load lands on the same edge as the transition
                // to RUN, so a simultaneous ref_wr/start uses the new pattern.
                if (ref_wr) begin
                    pattern_d = ref_pattern;
                end
                if (start) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end

            ST_RUN: begin
                busy    = 1'b1;
                corr_in = sample;
                if (sample_valid) begin
                    corr_ref = w_chip ? REF_POS : REF_NEG;
                    // The first chip overwrites whatever the correlator holds,
                    // so stale sums from earlier windows never leak in.
                    corr_clr = (idx_q == '0);
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end

            ST_WAIT: begin
                // The last chip has just landed in corr_acc; capture it.
                busy           = 1'b1;
                result_d       = corr_acc;
                detect_d       = w_over;
                result_valid_d = 1'b1;
                idx_d          = '0;
                state_d        = cont ? ST_RUN : ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            pattern_q      <= '1;
            result_q       <= 8'h00;
            result_valid_q <= 1'b0;
            detect_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            pattern_q      <= pattern_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            detect_q       <= detect_d;
        end
    end

    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign detect       = detect_q;

endmodule
`default_nettype wire

// File: tb/tb_correlator_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_correlator_sequencer
//  Description : Self-checking bench for correlator_sequencer with a
//                behavioural add/subtract correlator closing the loop.
//                Window vectors come from a table; window results are
//                matched through a scoreboard queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_correlator_sequencer;

    localparam int REF_LEN = 32;
    localparam int THRESH  = 40;

    logic               clk;
    logic               rst;
    logic               ref_wr;
    logic [REF_LEN-1:0] ref_pattern;
    logic               start;
    logic               cont;
    logic               sample_valid;
    logic [1:0]         sample;
    logic [1:0]         corr_in;
    logic [7:0]         corr_ref;
    logic               corr_clr;
    logic [7:0]         corr_acc;
    logic [7:0]         result;
    logic               result_valid;
    logic               detect;
    logic               busy;

    correlator_sequencer #(
        .REF_LEN (REF_LEN),
        .THRESH  (THRESH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .ref_wr       (ref_wr),
        .ref_pattern  (ref_pattern),
        .start        (start),
        .cont         (cont),
        .sample_valid (sample_valid),
        .sample       (sample),
        .corr_in      (corr_in),
        .corr_ref     (corr_ref),
        .corr_clr     (corr_clr),
        .corr_acc     (corr_acc),
        .result       (result),
        .result_valid (result_valid),
        .detect       (detect),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural correlator, starting from a deliberately stale sum.
    logic [7:0] acc_m = 8'h55;
    logic [7:0] in_ext;
    assign in_ext   = {{6{corr_in[1]}}, corr_in};
    assign corr_acc = acc_m;
    always @(posedge clk) begin
        if (corr_ref == 8'h01)
            acc_m <= (corr_clr ? 8'h00 : acc_m) + in_ext;
        else if (corr_ref == 8'hFF)
            acc_m <= (corr_clr ? 8'h00 : acc_m) - in_ext;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard of expected window results.
    typedef struct packed {
        logic [7:0]  res;
        logic        det;
        logic [31:0] cyc;
    } sb_t;
    sb_t sbq[$];
    sb_t mon_e;
    int  rv_seen    = 0;
    bit  watch_busy = 1'b0;
    int  busy_idle  = 0;

    always @(negedge clk) begin
        if (watch_busy && !busy) busy_idle++;
        if (result_valid) begin
            rv_seen++;
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_rv: result_valid with result %0h, expected no pulse", result);
            end else begin
                mon_e = sbq.pop_front();
                check("result", {24'h0, result}, {24'h0, mon_e.res});
                check("detect", {31'h0, detect}, {31'h0, mon_e.det});
                check("latency", cyc, mon_e.cyc);
            end
        end
    end

    // mode 0: ref_wr then start; mode 1: together; mode 2: start only.
    task automatic start_window(input logic [31:0] pat, input int mode);
        if (mode == 0) begin
            ref_wr = 1'b1; ref_pattern = pat;
            tick();
            ref_wr = 1'b0; ref_pattern = 32'($urandom);
        end
        ref_wr = (mode == 1); ref_pattern = (mode == 1) ? pat : ref_pattern;
        start  = 1'b1;
        #1;
        check("idle_ref", {24'h0, corr_ref}, 32'h0);
        tick();
        start = 1'b0; ref_wr = 1'b0;
    endtask

    // Feed one full window from RUN/idx 0, then drive the WAIT cycle.
    task automatic feed_window(input logic [31:0] pat, input logic [1:0] s1, input logic [1:0] s0,
                               input bit gaps, input logic [7:0] exp_res, input bit exp_det,
                               input bit cont_v, input int poke_at);
        sb_t e;
        for (int i = 0; i < REF_LEN; i++) begin
            if (gaps) begin
                int ng = int'($urandom_range(0, 2));
                for (int g = 0; g < ng; g++) begin
                    sample_valid = 1'b0; sample = 2'($urandom);
                    #1;
                    check("gap_ref", {24'h0, corr_ref}, 32'h0);
                    tick();
                end
            end
            sample_valid = 1'b1;
            sample       = pat[i] ? s1 : s0;
            ref_wr       = (i == poke_at);
            start        = (i == poke_at);
            if (i == poke_at) ref_pattern = ~pat;
            if (i == REF_LEN - 1) begin
                e.res = exp_res; e.det = exp_det; e.cyc = 32'(cyc + 2);
                sbq.push_back(e);
            end
            #1;
            check("chip_ref", {24'h0, corr_ref}, pat[i] ? 32'h01 : 32'hFF);
            check("chip_clr", {31'h0, corr_clr}, (i == 0) ? 32'h1 : 32'h0);
            check("chip_in",  {30'h0, corr_in}, {30'h0, sample});
            tick();
        end
        ref_wr = 1'b0; start = 1'b0;
        // WAIT: a valid sample here must be dropped.
        sample_valid = 1'b1; sample = s1; cont = cont_v;
        #1;
        check("wait_ref",  {24'h0, corr_ref}, 32'h0);
        check("wait_busy", {31'h0, busy}, 32'h1);
        tick();
        sample_valid = 1'b0; cont = 1'b0;
    endtask

    typedef struct packed {
        logic [31:0] pat;
        logic [1:0]  s1;
        logic [1:0]  s0;
        logic [1:0]  mode;
        logic        gaps;
        logic [7:0]  exp_res;
        logic        exp_det;
    } vec_t;
    vec_t vecs[9];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int rv0;
        //           pattern       s(+1) s(-1) mode gaps result  det
        vecs[0] = '{32'hFFFFFFFF, 2'b01, 2'b01, 2'd0, 1'b0, 8'h20, 1'b0}; // +32
        vecs[1] = '{32'hFFFFFFFF, 2'b10, 2'b10, 2'd0, 1'b0, 8'hC0, 1'b1}; // -64
        vecs[2] = '{32'hAAAAAAAA, 2'b01, 2'b10, 2'd1, 1'b0, 8'h30, 1'b1}; // +48
        vecs[3] = '{32'hAAAAAAAA, 2'b01, 2'b10, 2'd2, 1'b1, 8'h30, 1'b1}; // +48, gaps
        vecs[4] = '{32'h00FFFFFF, 2'b01, 2'b10, 2'd0, 1'b0, 8'h28, 1'b1}; // +40
        vecs[5] = '{32'h01FFFFFF, 2'b01, 2'b10, 2'd0, 1'b0, 8'h27, 1'b0}; // +39
        vecs[6] = '{32'h000000FF, 2'b10, 2'b01, 2'd0, 1'b0, 8'hD8, 1'b1}; // -40
        vecs[7] = '{32'h0000007F, 2'b10, 2'b01, 2'd0, 1'b0, 8'hD9, 1'b0}; // -39
        vecs[8] = '{32'h00000000, 2'b01, 2'b01, 2'd0, 1'b1, 8'hE0, 1'b0}; // -32

        rst = 1'b1; ref_wr = 1'b0; ref_pattern = '0; start = 1'b0; cont = 1'b0;
        sample_valid = 1'b1; sample = 2'b01;
        repeat (3) tick();
        check("rst_busy",   {31'h0, busy}, 32'h0);
        check("rst_result", {24'h0, result}, 32'h0);
        check("rst_rv",     {31'h0, result_valid}, 32'h0);
        check("rst_detect", {31'h0, detect}, 32'h0);
        check("rst_ref",    {24'h0, corr_ref}, 32'h0);
        check("rst_clr",    {31'h0, corr_clr}, 32'h0);
        check("rst_in",     {30'h0, corr_in}, 32'h0);
        rst = 1'b0; sample_valid = 1'b0;
        tick();

        for (int v = 0; v < 9; v++) begin
            start_window(vecs[v].pat, int'(vecs[v].mode));
            feed_window(vecs[v].pat, vecs[v].s1, vecs[v].s0, vecs[v].gaps,
                        vecs[v].exp_res, vecs[v].exp_det, 1'b0, -1);
        end
        repeat (4) tick();
        check("hold_result", {24'h0, result}, 32'hE0);

        // ref_wr/start during RUN are ignored; the old pattern survives.
        start_window(32'hFFFFFFFF, 1);
        feed_window(32'hFFFFFFFF, 2'b01, 2'b01, 1'b0, 8'h20, 1'b0, 1'b0, 5);
        start_window(32'h0, 2);
        feed_window(32'hFFFFFFFF, 2'b01, 2'b01, 1'b0, 8'h20, 1'b0, 1'b0, -1);
        repeat (3) tick();

        // Three chained windows over a stale correlator sum.
        start_window(32'h0F0F0F0F, 1);
        rv0 = rv_seen;
        watch_busy = 1'b1;
        feed_window(32'h0F0F0F0F, 2'b01, 2'b01, 1'b0, 8'h00, 1'b0, 1'b1, -1);
        feed_window(32'h0F0F0F0F, 2'b01, 2'b10, 1'b0, 8'h30, 1'b1, 1'b1, -1);
        feed_window(32'h0F0F0F0F, 2'b10, 2'b01, 1'b0, 8'hD0, 1'b1, 1'b0, -1);
        watch_busy = 1'b0;
        repeat (3) tick();
        check("cont_pulses", 32'(rv_seen - rv0), 32'd3);
        check("cont_no_idle", 32'(busy_idle), 32'd0);
        check("hold_detect", {31'h0, detect}, 32'h1);

        // Reset in the middle of a window.
        start_window(32'hFFFFFFFF, 0);
        for (int i = 0; i < 10; i++) begin
            sample_valid = 1'b1; sample = 2'b01;
            tick();
        end
        rst = 1'b1; sample_valid = 1'b1;
        tick();
        check("midrst_busy",   {31'h0, busy}, 32'h0);
        check("midrst_result", {24'h0, result}, 32'h0);
        check("midrst_rv",     {31'h0, result_valid}, 32'h0);
        check("midrst_detect", {31'h0, detect}, 32'h0);
        rst = 1'b0; sample_valid = 1'b0;
        tick();
        start_window(32'h0, 2);
        feed_window(32'hFFFFFFFF, 2'b10, 2'b10, 1'b1, 8'hC0, 1'b1, 1'b0, -1);
        repeat (4) tick();

        check("sb_empty", 32'(sbq.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
